// File: rtl/turn_sched.sv
// Two-player turn scheduler: routes the active player's buttons as rate-limited step strobes
// and sequences move/aim -> fire handshake -> swap. Optional turn timeout: define TURN_TIMEOUT_EN.
module turn_sched #(
  parameter int MOVE_DIV   = 4,
  parameter int AIM_DIV    = 8,
  parameter int TURN_TICKS = 600,
  parameter int TW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [4:0]    p0_btn,
  input  logic [4:0]    p1_btn,
  input  logic          fire_ack,
  output logic          left_x,
  output logic          right_x,
  output logic          left_aim,
  output logic          right_aim,
  output logic          fire_req,
  output logic          active_player,
  output logic          turn_start,
  output logic [TW-1:0] turn_left
);

  typedef struct packed {
    logic fire;
    logic aim_r;
    logic aim_l;
    logic right;
    logic left;
  } btn_t;

  typedef enum logic [1:0] {MOVE, FIRE, SWAP} state_t;

  localparam int XW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int AW = (AIM_DIV  > 1) ? $clog2(AIM_DIV)  : 1;

  state_t        state;
  logic          fire_prev;
  logic [XW-1:0] x_rep;
  logic [AW-1:0] aim_rep;
  btn_t          act;
  logic          x_one, aim_one, fire_rise, timeout;

  assign act       = active_player ? btn_t'(p1_btn) : btn_t'(p0_btn);
  assign x_one     = act.left ^ act.right;
  assign aim_one   = act.aim_l ^ act.aim_r;
  assign fire_rise = act.fire & ~fire_prev;

`ifdef TURN_TIMEOUT_EN
  // Counter is reloaded during SWAP so it already reads TURN_TICKS on the turn_start cycle.
  assign timeout = (state == MOVE) && tick && (turn_left <= TW'(1));

  always_ff @(posedge clk) begin
    if (reset)
      turn_left <= TW'(TURN_TICKS);
    else if (state == SWAP)
      turn_left <= TW'(TURN_TICKS);
    else if (state == MOVE && tick && turn_left != '0)
      turn_left <= turn_left - TW'(1);
  end
`else
  assign timeout   = 1'b0;
  assign turn_left = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= MOVE;
      active_player <= 1'b0;
      fire_prev     <= 1'b0;
      fire_req      <= 1'b0;
      turn_start    <= 1'b1;
      x_rep         <= '0;
      aim_rep       <= '0;
      left_x        <= 1'b0;
      right_x       <= 1'b0;
      left_aim      <= 1'b0;
      right_aim     <= 1'b0;
    end else begin
      left_x     <= 1'b0;
      right_x    <= 1'b0;
      left_aim   <= 1'b0;
      right_aim  <= 1'b0;
      turn_start <= 1'b0;
      fire_prev  <= act.fire;
      case (state)
        MOVE: begin
          // Fire beats a coinciding timeout; no step is issued on the tick that leaves MOVE.
          if (fire_rise) begin
            state    <= FIRE;
            fire_req <= 1'b1;
          end else if (timeout) begin
            state   <= SWAP;
            x_rep   <= '0;
            aim_rep <= '0;
          end else if (tick) begin
            if (!x_one)
              x_rep <= '0;
            else if (x_rep == '0) begin
              left_x  <= act.left;
              right_x <= act.right;
              x_rep   <= XW'(MOVE_DIV - 1);
            end else
              x_rep <= x_rep - XW'(1);

            if (!aim_one)
              aim_rep <= '0;
            else if (aim_rep == '0) begin
              left_aim  <= act.aim_l;
              right_aim <= act.aim_r;
              aim_rep   <= AW'(AIM_DIV - 1);
            end else
              aim_rep <= aim_rep - AW'(1);
          end
        end
        FIRE: begin
          if (fire_ack) begin
            state    <= SWAP;
            fire_req <= 1'b0;
            x_rep    <= '0;
            aim_rep  <= '0;
          end
        end
        SWAP: begin
          state         <= MOVE;
          active_player <= ~active_player;
          turn_start    <= 1'b1;
        end
        default: state <= MOVE;
      endcase
    end
  end

endmodule
